// File: rtl/otter_mcu_core.sv
// OTTER multicycle RV32I hart: FETCH -> EXEC (-> WB for loads) -> FETCH, with an INTR
// detour for the single machine-mode external interrupt.
module otter_mcu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intrpt,
    input  logic [31:0] imem_r_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] dmem_r_data,
    output logic        dmem_r_en,
    output logic        dmem_w_en,
    output logic [3:0]  dmem_w_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_w_data
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] MRET_WORD   = 32'h3020_0073;
    localparam logic [31:0] MCAUSE_EXT  = 32'h8000_000B;

    typedef enum logic [1:0] {FETCH, EXEC, WB, INTR} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        mie_reg, mie_next, mpie_reg, mpie_next;
    logic [31:0] mtvec_reg, mtvec_next, mepc_reg, mepc_next, mcause_reg, mcause_next;
    logic [1:0]  addr_lo_reg, addr_lo_next;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4, mem_addr;

    assign opcode = imem_r_data[6:0];
    assign rd     = imem_r_data[11:7];
    assign f3     = imem_r_data[14:12];
    assign rs1    = imem_r_data[19:15];
    assign rs2    = imem_r_data[24:20];
    assign imm_i  = {{20{imem_r_data[31]}}, imem_r_data[31:20]};
    assign imm_s  = {{20{imem_r_data[31]}}, imem_r_data[31:25], imem_r_data[11:7]};
    assign imm_b  = {{19{imem_r_data[31]}}, imem_r_data[31], imem_r_data[7],
                     imem_r_data[30:25], imem_r_data[11:8], 1'b0};
    assign imm_u  = {imem_r_data[31:12], 12'd0};
    assign imm_j  = {{11{imem_r_data[31]}}, imem_r_data[31], imem_r_data[19:12],
                     imem_r_data[20], imem_r_data[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc_reg + 32'd4;
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    // ALU shared by OP and OP-IMM; only register-register ops honour the SUB bit
    logic [31:0] alu_b, alu_out, sra_res;
    logic [4:0]  shamt;
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt   = alu_b[4:0];
    assign sra_res = $unsigned($signed(rs1_val) >>> shamt);

    always_comb begin
        alu_out = 32'd0;
        case (f3)
            3'b000: alu_out = (opcode == OPC_OP && imem_r_data[30]) ? rs1_val - alu_b
                                                                     : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = imem_r_data[30] ? sra_res : rs1_val >> shamt;
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    logic take;
    always_comb begin
        take = 1'b0;
        case (f3)
            3'b000: take = (rs1_val == rs2_val);
            3'b001: take = (rs1_val != rs2_val);
            3'b100: take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: take = (rs1_val < rs2_val);
            3'b111: take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    logic        is_csr, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, csr_src, csr_wval;
    assign is_csr   = (opcode == OPC_SYSTEM) && (f3[1:0] != 2'b00);
    assign csr_addr = imem_r_data[31:20];
    assign csr_src  = f3[2] ? {27'd0, rs1} : rs1_val;
    // set/clear with a zero source field is a pure read
    assign csr_we   = is_csr && ((f3[1:0] == 2'b01) || (rs1 != 5'd0));

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            12'h300: csr_rdata = {24'd0, mpie_reg, 3'b000, mie_reg, 3'b000};
            12'h305: csr_rdata = mtvec_reg;
            12'h341: csr_rdata = mepc_reg;
            12'h342: csr_rdata = mcause_reg;
            default: csr_rdata = 32'd0;
        endcase
        case (f3[1:0])
            2'b01:   csr_wval = csr_src;
            2'b10:   csr_wval = csr_rdata | csr_src;
            default: csr_wval = csr_rdata & ~csr_src;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    assign ld_byte = 8'(dmem_r_data >> {addr_lo_reg, 3'b000});
    assign ld_half = 16'(dmem_r_data >> {addr_lo_reg[1], 4'b0000});

    always_comb begin
        case (f3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_r_data;
        endcase
    end

    // Architectural next-state for PC, CSRs and register-file write port
    logic        rf_we;
    logic [31:0] rf_wdata;
    always_comb begin
        pc_next      = pc_reg;
        mie_next     = mie_reg;
        mpie_next    = mpie_reg;
        mtvec_next   = mtvec_reg;
        mepc_next    = mepc_reg;
        mcause_next  = mcause_reg;
        addr_lo_next = addr_lo_reg;
        rf_we        = 1'b0;
        rf_wdata     = 32'd0;
        case (state_reg)
            EXEC: begin
                pc_next = pc_plus4;
                case (opcode)
                    OPC_LUI:    begin rf_we = 1'b1; rf_wdata = imm_u; end
                    OPC_AUIPC:  begin rf_we = 1'b1; rf_wdata = pc_reg + imm_u; end
                    OPC_JAL:    begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_next = pc_reg + imm_j; end
                    OPC_JALR:   begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_next  = (rs1_val + imm_i) & ~32'd1;
                    end
                    OPC_BRANCH: if (take) pc_next = pc_reg + imm_b;
                    OPC_LOAD:   begin pc_next = pc_reg; addr_lo_next = mem_addr[1:0]; end
                    OPC_OP, OPC_OPIMM: begin rf_we = 1'b1; rf_wdata = alu_out; end
                    OPC_SYSTEM: begin
                        if (is_csr) begin
                            rf_we    = 1'b1;
                            rf_wdata = csr_rdata;
                            if (csr_we) begin
                                case (csr_addr)
                                    12'h300: begin mie_next = csr_wval[3]; mpie_next = csr_wval[7]; end
                                    12'h305: mtvec_next  = csr_wval;
                                    12'h341: mepc_next   = csr_wval;
                                    12'h342: mcause_next = csr_wval;
                                    default: ;
                                endcase
                            end
                        end else if (imem_r_data == MRET_WORD) begin
                            pc_next   = mepc_reg;
                            mie_next  = mpie_reg;
                            mpie_next = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            WB: begin
                rf_we    = 1'b1;
                rf_wdata = load_data;
                pc_next  = pc_plus4;
            end
            INTR: begin
                mepc_next   = pc_reg;
                mcause_next = MCAUSE_EXT;
                mpie_next   = mie_reg;
                mie_next    = 1'b0;
                pc_next     = {mtvec_reg[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            mie_reg     <= 1'b0;
            mpie_reg    <= 1'b0;
            mtvec_reg   <= 32'd0;
            mepc_reg    <= 32'd0;
            mcause_reg  <= 32'd0;
            addr_lo_reg <= 2'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            mie_reg     <= mie_next;
            mpie_reg    <= mpie_next;
            mtvec_reg   <= mtvec_next;
            mepc_reg    <= mepc_next;
            mcause_reg  <= mcause_next;
            addr_lo_reg <= addr_lo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0)
            regs[rd] <= rf_wdata;
    end

    // Interrupt check uses the post-retire MIE so a CSR write or MRET takes effect at once
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   state_next = EXEC;
            EXEC:    state_next = (opcode == OPC_LOAD) ? WB
                                : ((intrpt && mie_next) ? INTR : FETCH);
            WB:      state_next = (intrpt && mie_next) ? INTR : FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_addr   = pc_reg;
        dmem_addr   = mem_addr;
        dmem_w_data = rs2_val << {mem_addr[1:0], 3'b000};
        dmem_r_en   = (state_reg == EXEC) && (opcode == OPC_LOAD);
        dmem_w_en   = (state_reg == EXEC) && (opcode == OPC_STORE);
        dmem_w_strb = 4'b0000;
        if (dmem_w_en) begin
            case (f3[1:0])
                2'b00:   dmem_w_strb = 4'b0001 << mem_addr[1:0];
                2'b01:   dmem_w_strb = 4'b0011 << {mem_addr[1], 1'b0};
                default: dmem_w_strb = 4'b1111;
            endcase
        end
    end
endmodule

// File: tb/tb_otter_mcu_core.sv
// Scoreboard bench for otter_mcu_core: a directed program whose data-memory accesses
// (address, strobes, data and cycle) are predicted by hand and checked by a monitor.
module tb_otter_mcu_core;
    logic        clk = 1'b0;
    logic        rst, intrpt;
    logic [31:0] imem_r_data, imem_addr, dmem_r_data, dmem_addr, dmem_w_data;
    logic        dmem_r_en, dmem_w_en;
    logic [3:0]  dmem_w_strb;

    otter_mcu_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .intrpt(intrpt),
        .imem_r_data(imem_r_data), .imem_addr(imem_addr),
        .dmem_r_data(dmem_r_data), .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en),
        .dmem_w_strb(dmem_w_strb), .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:511];

    always @(posedge clk) imem_r_data <= imem[imem_addr[8:2]];
    always @(posedge clk) begin
        if (dmem_r_en) dmem_r_data <= dmem[dmem_addr[10:2]];
        if (dmem_w_en)
            for (int b = 0; b < 4; b++)
                if (dmem_w_strb[b]) dmem[dmem_addr[10:2]][8*b +: 8] <= dmem_w_data[8*b +: 8];
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    txn_t exp_q[$];
    txn_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && (dmem_w_en || dmem_r_en)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access: got we=%b re=%b addr=%h strb=%b data=%h cyc=%0d, required no access",
                         dmem_w_en, dmem_r_en, dmem_addr, dmem_w_strb, dmem_w_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (dmem_w_en !== e.wr || dmem_r_en === e.wr || dmem_addr !== e.addr ||
                    dmem_w_strb !== e.strb || (e.wr && dmem_w_data !== e.data) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mem_txn: got we=%b addr=%h strb=%b data=%h cyc=%0d, required we=%b addr=%h strb=%b data=%h cyc=%0d",
                             dmem_w_en, dmem_addr, dmem_w_strb, dmem_w_data, cyc,
                             e.wr, e.addr, e.strb, e.data, e.cyc);
                end else begin
                    $display("txn %s addr=%h strb=%b data=%h cyc=%0d ok",
                             e.wr ? "store" : "load ", dmem_addr, dmem_w_strb, dmem_w_data, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int c);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.strb = s; t.data = d; t.cyc = c;
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [31:0] a, input int c);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.strb = 4'b0000; t.data = 32'd0; t.cyc = c;
        exp_q.push_back(t);
    endtask

    task automatic wait_store(input logic [31:0] a, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (dmem_w_en && dmem_addr == a) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no store to %h within 300 cycles, required one", name, a);
        end
    endtask

    localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011, SYS = 7'b1110011, JALR = 7'b1100111;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2, input logic [2:0] f3);
        return {imm[11:5], r2, 5'd0, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 512; i++) dmem[i] = 32'd0;
        dmem[32'h200 >> 2] = 32'h80FF_1234;

        imem[32'h00 >> 2] = enc_i(12'd5, 0, 3'b000, 1, OPIMM);
        imem[32'h04 >> 2] = enc_i(12'hFF9, 1, 3'b000, 2, OPIMM);
        imem[32'h08 >> 2] = enc_r(7'h20, 2, 1, 3'b000, 3);
        imem[32'h0C >> 2] = enc_s(12'h400, 2, 3'b010);
        imem[32'h10 >> 2] = enc_s(12'h404, 3, 3'b010);
        imem[32'h14 >> 2] = enc_i(12'h0AB, 0, 3'b000, 5, OPIMM);
        imem[32'h18 >> 2] = enc_s(12'h103, 5, 3'b000);
        imem[32'h1C >> 2] = enc_i(12'h203, 0, 3'b000, 6, LOAD);
        imem[32'h20 >> 2] = enc_i(12'h202, 0, 3'b101, 7, LOAD);
        imem[32'h24 >> 2] = enc_s(12'h408, 6, 3'b010);
        imem[32'h28 >> 2] = enc_s(12'h40C, 7, 3'b010);
        imem[32'h2C >> 2] = enc_s(12'h40E, 5, 3'b001);
        imem[32'h30 >> 2] = enc_b(13'd16, 2, 1, 3'b001);
        imem[32'h34 >> 2] = enc_s(12'h410, 1, 3'b010);
        imem[32'h40 >> 2] = enc_j(21'd12, 0);
        imem[32'h44 >> 2] = enc_s(12'h414, 8, 3'b010);
        imem[32'h48 >> 2] = enc_j(21'd12, 0);
        imem[32'h4C >> 2] = enc_j(21'h1FFFF8, 8);
        imem[32'h54 >> 2] = enc_i(12'd28, 1, 3'b001, 9, OPIMM);
        imem[32'h58 >> 2] = enc_i(12'h401, 2, 3'b101, 10, OPIMM);
        imem[32'h5C >> 2] = enc_r(7'h00, 2, 1, 3'b011, 11);
        imem[32'h60 >> 2] = enc_s(12'h418, 9, 3'b010);
        imem[32'h64 >> 2] = enc_s(12'h41C, 10, 3'b010);
        imem[32'h68 >> 2] = enc_s(12'h420, 11, 3'b010);
        imem[32'h6C >> 2] = enc_i(12'h100, 0, 3'b000, 12, OPIMM);
        imem[32'h70 >> 2] = enc_i(12'h305, 12, 3'b001, 0, SYS);
        imem[32'h74 >> 2] = enc_i(12'h300, 5'd8, 3'b110, 13, SYS);
        imem[32'h78 >> 2] = enc_i(12'h300, 0, 3'b010, 17, SYS);
        imem[32'h7C >> 2] = enc_s(12'h50C, 13, 3'b010);
        imem[32'h80 >> 2] = enc_s(12'h510, 17, 3'b010);
        imem[32'h84 >> 2] = enc_i(12'h091, 0, 3'b000, 18, JALR);
        imem[32'h90 >> 2] = enc_s(12'h514, 18, 3'b010);
        imem[32'h94 >> 2] = enc_s(12'h518, 1, 3'b010);
        imem[32'h100 >> 2] = enc_i(12'h341, 0, 3'b010, 14, SYS);
        imem[32'h104 >> 2] = enc_i(12'h300, 0, 3'b010, 15, SYS);
        imem[32'h108 >> 2] = enc_i(12'h342, 0, 3'b010, 16, SYS);
        imem[32'h10C >> 2] = enc_s(12'h500, 14, 3'b010);
        imem[32'h110 >> 2] = enc_s(12'h504, 15, 3'b010);
        imem[32'h114 >> 2] = enc_s(12'h508, 16, 3'b010);
        imem[32'h118 >> 2] = 32'h3020_0073;

        // Hand-computed access trace: CPI 2, loads 3, interrupt entry 1 extra cycle
        push_w(32'h400, 4'b1111, 32'hFFFF_FFFE, 7);
        push_w(32'h404, 4'b1111, 32'h0000_0007, 9);
        push_w(32'h103, 4'b1000, 32'hAB00_0000, 13);
        push_r(32'h203, 15);
        push_r(32'h202, 18);
        push_w(32'h408, 4'b1111, 32'hFFFF_FF80, 21);
        push_w(32'h40C, 4'b1111, 32'h0000_80FF, 23);
        push_w(32'h40E, 4'b1100, 32'h00AB_0000, 25);
        push_w(32'h414, 4'b1111, 32'h0000_0050, 33);
        push_w(32'h418, 4'b1111, 32'h5000_0000, 43);
        push_w(32'h41C, 4'b1111, 32'hFFFF_FFFF, 45);
        push_w(32'h420, 4'b1111, 32'h0000_0001, 47);
        push_w(32'h500, 4'b1111, 32'h0000_0078, 62);
        push_w(32'h504, 4'b1111, 32'h0000_0080, 64);
        push_w(32'h508, 4'b1111, 32'h8000_000B, 66);
        push_w(32'h50C, 4'b1111, 32'h0000_0000, 72);
        push_w(32'h510, 4'b1111, 32'h0000_0088, 74);
        push_w(32'h514, 4'b1111, 32'h0000_0088, 78);
        push_w(32'h518, 4'b1111, 32'h0000_0005, 80);

        rst = 1'b1;
        intrpt = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_r_en", {31'd0, dmem_r_en}, 32'd0);
        chk("reset_w_en", {31'd0, dmem_w_en}, 32'd0);
        chk("reset_strb", {28'd0, dmem_w_strb}, 32'd0);

        rst = 1'b0;
        intrpt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fetch_pc_cyc%0d", i), imem_addr, 32'((i / 2) * 4));
            @(negedge clk);
        end

        wait_store(32'h500, "isr_entry");
        intrpt = 1'b0;

        wait_store(32'h518, "reset_store");
        #2 rst = 1'b1;
        #1;
        chk("abort_w_en", {31'd0, dmem_w_en}, 32'd0);
        chk("abort_strb", {28'd0, dmem_w_strb}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_write", dmem[32'h518 >> 2], 32'h0);
        chk("abort_pc", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("release_pc", imem_addr, 32'h0);
        @(negedge clk);
        chk("release_exec_pc", imem_addr, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units, required finish");
        $fatal(1, "watchdog");
    end
endmodule
